mem_access_unit: RTL and testbench

- Memory-side responder to the multicycle control FSM's load/store strobes (memwrite size code, ltype, dtype).
- Turns one controller request into one or two 32-bit beats on a word-wide memory port with byte enables and a req/ack handshake.
- Returns sign- or zero-extended 64-bit load data and a one-cycle done pulse; busy is used to stall the control FSM in its MEM_* states.

---
 rtl/mem_access_unit.sv | 201 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Memory-side responder for the multicycle control FSM. One controller
//   request (load/store strobes) becomes one or two 32-bit beats on a
//   word-wide memory port. Load results are sign/zero extended to 64 bits.
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   req                  start access (sampled only in IDLE)
//   memwrite[1:0]        00 load, 01 SW, 10 SB, 11 SD
//   ltype[1:0]           00 word, 10 byte signed, 01 byte unsigned, 11 = word
//   dtype                dword load (overrides ltype)
//   addr[AW-1:0]         byte address
//   wdata[DW-1:0]        store data
//   rdata[DW-1:0]        extended load result, held until the next load
//   busy                 high in BEAT0, BEAT1 and DONE
//   done                 one-cycle completion pulse
//   err                  misaligned access trapped (MISALIGN_TRAP_EN only)
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata   beat request side
//   mem_rdata/mem_ack    beat completion side
//
// Handshake: mem_req is a level that stays high (with stable mem_we,
// mem_addr, mem_be, mem_wdata) until the memory returns a single-cycle
// mem_ack; the beat completes on the clock edge where mem_ack is high and
// mem_rdata is sampled on that same edge. mem_ack outside a beat is ignored.
//
// Build option: define MISALIGN_TRAP_EN to trap misaligned word/dword
// accesses (no memory beat, done with err=1). Without it, low address bits
// are dropped so word/dword accesses are forced aligned and err is tied 0.
module mem_access_unit #(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [1:0]    memwrite,
  input  logic [1:0]    ltype,
  input  logic          dtype,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-3:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Request fields latched in IDLE and used for the whole access
  logic [1:0]    mw_q;
  logic [1:0]    lt_q;
  logic          dt_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [31:0]   lo_q;      // beat-0 data of a dword load

  logic          is_load;
  logic          two_beat;
  logic          byte_store;
  logic [AW-3:0] base_waddr;

  assign is_load    = (mw_q == 2'b00);
  assign two_beat   = (mw_q == 2'b11) || (is_load && dt_q);
  assign byte_store = (mw_q == 2'b10);
  // Dword accesses start on an even word; dropping addr[2] forces alignment
  assign base_waddr = two_beat ? {addr_q[AW-1:3], 1'b0} : addr_q[AW-1:2];

  // Misalignment decode works on the live inputs so IDLE can skip the beats
  logic trap;
`ifdef MISALIGN_TRAP_EN
  logic in_two;
  logic in_word;
  logic err_q;
  assign in_two  = (memwrite == 2'b11) || ((memwrite == 2'b00) && dtype);
  assign in_word = (memwrite == 2'b01) ||
                   ((memwrite == 2'b00) && !dtype && (ltype[1] == ltype[0]));
  assign trap    = (in_word && (addr[1:0] != 2'b00)) ||
                   (in_two  && (addr[2:0] != 3'b000));
`else
  assign trap    = 1'b0;
`endif

  // Single-beat load extension; lane n is the byte at address offset n
  logic [7:0]    lane_byte;
  logic [DW-1:0] load_ext;

  always_comb begin
    lane_byte = mem_rdata[7:0];
    case (addr_q[1:0])
      2'd0: lane_byte = mem_rdata[7:0];
      2'd1: lane_byte = mem_rdata[15:8];
      2'd2: lane_byte = mem_rdata[23:16];
      2'd3: lane_byte = mem_rdata[31:24];
      default: lane_byte = mem_rdata[7:0];
    endcase
    case (lt_q)
      2'b10:   load_ext = {{(DW-8){lane_byte[7]}}, lane_byte};
      2'b01:   load_ext = {{(DW-8){1'b0}}, lane_byte};
      default: load_ext = {{(DW-32){mem_rdata[31]}}, mem_rdata};
    endcase
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req) state_d = trap ? S_DONE : S_BEAT0;
      S_BEAT0: if (mem_ack) state_d = two_beat ? S_BEAT1 : S_DONE;
      S_BEAT1: if (mem_ack) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from state only, so reset drops mem_req at once
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = 4'b0000;
    mem_wdata = 32'h0;
    case (state_q)
      S_BEAT0: begin
        mem_req  = 1'b1;
        mem_we   = !is_load;
        mem_addr = base_waddr;
        if (byte_store) begin
          mem_be    = 4'b0001 << addr_q[1:0];
          mem_wdata = {4{wdata_q[7:0]}};
        end else begin
          mem_be    = 4'b1111;
          mem_wdata = wdata_q[31:0];
        end
      end
      S_BEAT1: begin
        mem_req   = 1'b1;
        mem_we    = !is_load;
        mem_addr  = base_waddr + {{(AW-3){1'b0}}, 1'b1};
        mem_be    = 4'b1111;
        mem_wdata = wdata_q[DW-1:32];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      mw_q    <= 2'b00;
      lt_q    <= 2'b00;
      dt_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= 32'h0;
      rdata   <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && req) begin
        mw_q    <= memwrite;
        lt_q    <= ltype;
        dt_q    <= dtype;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if ((state_q == S_BEAT0) && mem_ack && is_load) begin
        if (two_beat) lo_q  <= mem_rdata;
        else          rdata <= load_ext;
      end
      if ((state_q == S_BEAT1) && mem_ack && is_load) begin
        rdata <= {mem_rdata, lo_q};
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          err_q <= 1'b0;
    else if ((state_q == S_IDLE) && req) err_q <= trap;
  end
  assign err = done && err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed accesses from the feature list, a
// reset-mid-dword case, then randomized accesses. Expected beats and load
// results come from byte-address arithmetic in run_access.
module tb_mem_access_unit;
  localparam int AW = 32;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic [1:0]    memwrite;
  logic [1:0]    ltype;
  logic          dtype;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          done;
  logic          err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-3:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_ack;

  int vectors     = 0;
  int miscompares = 0;
  logic [DW-1:0] model_rdata;
  logic [DW-1:0] exp_q[$];

  mem_access_unit #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .memwrite(memwrite), .ltype(ltype),
    .dtype(dtype), .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy),
    .done(done), .err(err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one access and walks it cycle by cycle; the memory acks each
  // beat after lat wait cycles with rd0 / rd1.
  task automatic run_access(input logic [1:0] mw, input logic [1:0] lt, input logic dt,
                            input logic [31:0] a, input logic [63:0] wd, input int lat,
                            input logic [31:0] rd0, input logic [31:0] rd1);
    logic        is_load, two, word, trap, trap_en;
    logic [29:0] wa0, wa1;
    logic [3:0]  be0;
    logic [31:0] wd0;
    logic [7:0]  bsel;
    logic [63:0] exp_rd;
    int          nb;
`ifdef MISALIGN_TRAP_EN
    trap_en = 1'b1;
`else
    trap_en = 1'b0;
`endif
    is_load = (mw == 2'd0);
    two     = (mw == 2'd3) || (is_load && dt);
    word    = (mw == 2'd1) || (is_load && !dt && (lt == 2'd0 || lt == 2'd3));
    trap    = trap_en && ((word && (a % 4 != 0)) || (two && (a % 8 != 0)));
    nb      = trap ? 0 : (two ? 2 : 1);
    wa0     = two ? 30'((a / 8) * 2) : 30'(a / 4);
    wa1     = 30'((32'(wa0) + 32'd1) % 32'h4000_0000);
    be0     = (mw == 2'd2) ? 4'(1 << (a % 4)) : 4'hF;
    wd0     = (mw == 2'd2) ? 32'(wd[7:0]) * 32'h0101_0101 : wd[31:0];
    if (!is_load || trap) begin
      exp_rd = model_rdata;
    end else if (two) begin
      exp_rd = {rd1, rd0};
    end else if (lt == 2'd1 || lt == 2'd2) begin
      bsel   = 8'(rd0 >> (8 * (a % 4)));
      exp_rd = 64'(bsel);
      if (lt == 2'd2 && bsel >= 8'd128) exp_rd = exp_rd - 64'd256;
    end else begin
      exp_rd = 64'(rd0);
      if (rd0 >= 32'h8000_0000) exp_rd = exp_rd - 64'h1_0000_0000;
    end
    exp_q.push_back(exp_rd);
    model_rdata = exp_rd;

    @(negedge clk);
    req = 1'b1; memwrite = mw; ltype = lt; dtype = dt; addr = a; wdata = wd;
    @(negedge clk);
    // scramble inputs: the access must run on the latched copy
    req = 1'b0; memwrite = 2'($urandom); ltype = 2'($urandom); dtype = 1'($urandom);
    addr = $urandom; wdata = {$urandom, $urandom};
    for (int b = 0; b < nb; b++) begin
      for (int w = 0; w <= lat; w++) begin
        chk("mem_req",  64'(mem_req), 64'd1);
        chk("busy",     64'(busy),    64'd1);
        chk("done",     64'(done),    64'd0);
        chk("mem_we",   64'(mem_we),  64'(!is_load));
        chk("mem_addr", 64'(mem_addr), 64'(b == 0 ? wa0 : wa1));
        chk("mem_be",   64'(mem_be),   64'(b == 0 ? be0 : 4'hF));
        if (!is_load) chk("mem_wdata", 64'(mem_wdata), 64'(b == 0 ? wd0 : wd[63:32]));
        if (w == lat) begin
          mem_ack   = 1'b1;
          mem_rdata = (b == 0) ? rd0 : rd1;
        end
        req = 1'($urandom_range(0, 1));
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end
    end
    req = 1'b0;
    chk("done_pulse", 64'(done),    64'd1);
    chk("done_busy",  64'(busy),    64'd1);
    chk("done_mreq",  64'(mem_req), 64'd0);
    chk("err",        64'(err),     64'(trap));
    chk("rdata",      rdata,        exp_q.pop_front());
    @(negedge clk);
    chk("idle_done",  64'(done),    64'd0);
    chk("idle_busy",  64'(busy),    64'd0);
    chk("idle_mreq",  64'(mem_req), 64'd0);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; memwrite = 2'd0; ltype = 2'd0; dtype = 1'b0;
    addr = '0; wdata = '0; mem_rdata = 32'h0; mem_ack = 1'b0;
    model_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_rdata",     rdata,             64'd0);
    chk("rst_busy",      64'(busy),         64'd0);
    chk("rst_done",      64'(done),         64'd0);
    chk("rst_err",       64'(err),          64'd0);
    chk("rst_mem_req",   64'(mem_req),      64'd0);
    chk("rst_mem_we",    64'(mem_we),       64'd0);
    chk("rst_mem_addr",  64'(mem_addr),     64'd0);
    chk("rst_mem_be",    64'(mem_be),       64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata),    64'd0);
    reset = 1'b0;

    // stray ack in IDLE
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk); mem_ack = 1'b0;
    chk("idle_ack_busy",  64'(busy), 64'd0);
    chk("idle_ack_rdata", rdata,     64'd0);

    // directed cases
    run_access(2'b00, 2'b00, 1'b0, 32'h100, 64'h0, 2, 32'h8000_0001, 32'h0);          // LW
    run_access(2'b00, 2'b10, 1'b0, 32'h103, 64'h0, 1, 32'h9A00_0000, 32'h0);          // LB
    run_access(2'b00, 2'b01, 1'b0, 32'h103, 64'h0, 0, 32'h9A00_0000, 32'h0);          // LBU
    run_access(2'b10, 2'b00, 1'b0, 32'h202, 64'h55, 1, 32'h0, 32'h0);                 // SB
    run_access(2'b11, 2'b00, 1'b0, 32'h300, 64'h1122_3344_5566_7788, 0, 32'h0, 32'h0); // SD
    run_access(2'b00, 2'b00, 1'b1, 32'h408, 64'h0, 1, 32'hCAFE_0001, 32'h8765_4321);  // LD
    run_access(2'b00, 2'b11, 1'b0, 32'h20C, 64'h0, 0, 32'h7FFF_0000, 32'h0);          // ltype 11
    run_access(2'b01, 2'b00, 1'b0, 32'h104, 64'hFFFF_0000_A5A5_5A5A, 2, 32'h0, 32'h0); // SW
    run_access(2'b00, 2'b00, 1'b0, 32'h101, 64'h0, 0, 32'h1234_5678, 32'h0);          // misaligned LW
    run_access(2'b11, 2'b00, 1'b0, 32'h30C, 64'hAAAA_BBBB_CCCC_DDDD, 0, 32'h0, 32'h0); // misaligned SD
    run_access(2'b00, 2'b00, 1'b1, 32'hFFFF_FFF8, 64'h0, 0, 32'h0000_0011, 32'hFFFF_FF22); // top LD

    // reset while waiting on the beat-1 ack of a dword load
    @(negedge clk);
    req = 1'b1; memwrite = 2'b00; ltype = 2'b00; dtype = 1'b1; addr = 32'h400; wdata = '0;
    @(negedge clk);
    req = 1'b0;
    chk("ldrst_beat0_addr", 64'(mem_addr), 64'h100);
    mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("ldrst_beat1_addr", 64'(mem_addr), 64'h101);
    chk("ldrst_beat1_req",  64'(mem_req),  64'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("ldrst_mem_req", 64'(mem_req), 64'd0);
    chk("ldrst_busy",    64'(busy),    64'd0);
    chk("ldrst_done",    64'(done),    64'd0);
    chk("ldrst_rdata",   rdata,        64'd0);
    model_rdata = '0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); mem_ack = 1'b1; mem_rdata = $urandom;
    @(negedge clk); mem_ack = 1'b0;
    chk("late_ack_busy",  64'(busy),    64'd0);
    chk("late_ack_done",  64'(done),    64'd0);
    chk("late_ack_req",   64'(mem_req), 64'd0);
    chk("late_ack_rdata", rdata,        64'd0);
    run_access(2'b00, 2'b00, 1'b0, 32'h110, 64'h0, 1, 32'h0BAD_F00D, 32'h0);

    // randomized accesses
    for (int i = 0; i < 60; i++) begin
      run_access(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom, {$urandom, $urandom}, $urandom_range(0, 2), $urandom, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
